// File: rtl/ip_tx_arbiter_if.sv
// Bundle of requester-side and encoder-side handshake signals for ip_tx_arbiter.
// The master modport is the arbiter's view; the slave modport is the
// requester/encoder environment's view.
interface ip_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int SEG_W = 2256,
  parameter int SEL_W = 2
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*SEG_W-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   enc_valid;
  logic                   enc_ready;
  logic [SEG_W-1:0]       enc_data;
  logic [15:0]            enc_ident;
  logic [SEL_W-1:0]       enc_src;
  logic                   busy;
  logic [31:0]            pkt_cnt;

  modport master (
    input  req_valid, req_data, enc_ready,
    output req_ready, enc_valid, enc_data, enc_ident, enc_src, busy, pkt_cnt
  );

  modport slave (
    output req_valid, req_data, enc_ready,
    input  req_ready, enc_valid, enc_data, enc_ident, enc_src, busy, pkt_cnt
  );
endinterface

// File: rtl/ip_tx_arbiter.sv
// Round-robin scheduler that shares one IP encoder between N_REQ TCP
// session requesters. Each grant moves one whole segment into a holding
// register, stamps it with a never-zero, increasing 16-bit IP ident and
// offers it to the encoder; an optional idle gap follows every accepted packet.
module ip_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int PAYLOAD_LEN = 262,
  parameter int TCPH_LEN    = 20,
  parameter int IPG_CYCLES  = 2,
  localparam int SEG_W      = (PAYLOAD_LEN + TCPH_LEN) * 8,
  localparam int SEL_W      = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input logic            clk,
  input logic            rst_n,
  ip_tx_arbiter_if.master bus
);

  localparam int GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state;
  state_t           state_next;
  logic [SEL_W-1:0] rr_ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      ident_ctr;
  logic             enc_valid_q;
  logic [SEG_W-1:0] enc_data_q;
  logic [15:0]      enc_ident_q;
  logic [SEL_W-1:0] enc_src_q;
  logic [31:0]      pkt_cnt_q;

  logic             found;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] cand;
  logic [SEG_W-1:0] win_data;

  // Search rr_ptr+1, rr_ptr+2, ... for the first requester with a segment, and mux its data.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = '0;
    win_data = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = SEL_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == SEL_W'(i)) begin
        win_data = bus.req_data[i*SEG_W +: SEG_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state: a grant always transfers, since only a valid requester can win.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (found) state_next = SEND;
      SEND: if (bus.enc_ready) state_next = (IPG_CYCLES > 0) ? GAP : IDLE;
      GAP:  if (gap_cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: the one-hot grant is combinational and only exists in IDLE.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_ready[i] = (state == IDLE) && found && (winner == SEL_W'(i));
    end
  end

  // Datapath: capture the granted segment, count accepts, advance ident and run the gap timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= SEL_W'(N_REQ - 1);
      gap_cnt     <= '0;
      ident_ctr   <= 16'h0001;
      enc_valid_q <= 1'b0;
      enc_data_q  <= '0;
      enc_ident_q <= '0;
      enc_src_q   <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            enc_data_q  <= win_data;
            enc_ident_q <= ident_ctr;
            enc_src_q   <= winner;
            rr_ptr      <= winner;
            enc_valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (bus.enc_ready) begin
            pkt_cnt_q   <= pkt_cnt_q + 32'd1;
            ident_ctr   <= (ident_ctr == 16'hFFFF) ? 16'h0001 : ident_ctr + 16'h0001;
            enc_valid_q <= 1'b0;
            if (IPG_CYCLES > 0) gap_cnt <= GAP_W'(IPG_CYCLES - 1);
          end
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.enc_valid = enc_valid_q;
  assign bus.enc_data  = enc_data_q;
  assign bus.enc_ident = enc_ident_q;
  assign bus.enc_src   = enc_src_q;
  assign bus.pkt_cnt   = pkt_cnt_q;
  assign bus.busy      = (state != IDLE);

endmodule
